// File: rtl/fmap_flatten.sv
// rtl/fmap_flatten.sv - capture a pooled 3-channel feature map, replay it as a channel-major ready/valid stream
// Optional FMAP_PINGPONG_EN: two storage banks so a new frame can fill while the previous one drains.
module fmap_flatten #(
    parameter int DATA_BITS = 12,
    parameter int MAP_W     = 6,
    parameter int MAP_H     = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [DATA_BITS-1:0] in0,
    input  logic signed [DATA_BITS-1:0] in1,
    input  logic signed [DATA_BITS-1:0] in2,
    input  logic                        valid_in,
    output logic signed [DATA_BITS-1:0] out_data,
    output logic [7:0]                  out_index,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        frame_done,
    output logic                        overflow
);
    localparam int N  = MAP_W * MAP_H;
    localparam int F  = 3 * N;
`ifdef FMAP_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int PW = $clog2(N);
    localparam int AW = $clog2(NB * N);

    typedef enum logic {S_FILL, S_DRAIN} state_t;
    state_t state, state_nx;

    logic signed [DATA_BITS-1:0] mem0 [NB*N];
    logic signed [DATA_BITS-1:0] mem1 [NB*N];
    logic signed [DATA_BITS-1:0] mem2 [NB*N];

    logic [PW-1:0]               wr_cnt;
    logic [PW-1:0]               rd_pix;
    logic [1:0]                  rd_ch;
    logic [7:0]                  rd_cnt;
    logic                        wr_bank;
    logic                        rd_bank;
    logic                        accept;
    logic                        wr_en;
    logic                        wr_done;
    logic                        drain_go;
    logic                        hs;
    logic                        ld_en;
    logic                        fin;
    logic                        ovf_set;
    logic [AW-1:0]               wr_addr;
    logic [AW-1:0]               rd_addr;
    logic signed [DATA_BITS-1:0] rd_word;

`ifdef FMAP_PINGPONG_EN
    logic [1:0] bank_full;

    // Banks fill and drain in the same A,B,A,... order, so an idle drain side always points at the bank being filled.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
        end else begin
            if (wr_done) begin
                bank_full[wr_bank] <= 1'b1;
                wr_bank            <= ~wr_bank;
            end
            if (fin) begin
                bank_full[rd_bank] <= 1'b0;
                rd_bank            <= ~rd_bank;
            end
        end
    end

    assign accept   = ~bank_full[wr_bank];
    assign drain_go = wr_done | bank_full[rd_bank];
`else
    assign wr_bank  = 1'b0;
    assign rd_bank  = 1'b0;
    assign accept   = (state == S_FILL);
    assign drain_go = wr_done;
`endif

    assign wr_addr = (wr_bank ? AW'(N) : AW'(0)) + AW'(wr_cnt);
    assign rd_addr = (rd_bank ? AW'(N) : AW'(0)) + AW'(rd_pix);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem0[wr_addr] <= in0;
            mem1[wr_addr] <= in1;
            mem2[wr_addr] <= in2;
        end
    end

    always_comb begin
        rd_word = mem0[rd_addr];
        if (rd_ch == 2'd1)
            rd_word = mem1[rd_addr];
        else if (rd_ch == 2'd2)
            rd_word = mem2[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_FILL;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FILL:  if (drain_go) state_nx = S_DRAIN;
            S_DRAIN: if (fin)      state_nx = S_FILL;
            default: state_nx = S_FILL;
        endcase
    end

    // Output register is loaded on drain entry and again on every non-final handshake (prefetch).
    always_comb begin
        hs      = out_valid & out_ready;
        wr_en   = valid_in & accept;
        ovf_set = valid_in & ~accept;
        wr_done = wr_en & (wr_cnt == PW'(N - 1));
        ld_en   = 1'b0;
        fin     = 1'b0;
        if (state == S_DRAIN) begin
            ld_en = ~out_valid | (hs & ~out_last);
            fin   = hs & out_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= '0;
            out_index  <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            rd_ch      <= '0;
            rd_pix     <= '0;
        end else begin
            frame_done <= fin;
            if (ovf_set)
                overflow <= 1'b1;
            if (wr_en)
                wr_cnt <= wr_done ? '0 : wr_cnt + PW'(1);
            if (ld_en) begin
                out_data  <= rd_word;
                out_index <= rd_cnt;
                out_last  <= (rd_cnt == 8'(F - 1));
                out_valid <= 1'b1;
                if (rd_cnt == 8'(F - 1)) begin
                    rd_cnt <= '0;
                    rd_ch  <= '0;
                    rd_pix <= '0;
                end else begin
                    rd_cnt <= rd_cnt + 8'd1;
                    if (rd_pix == PW'(N - 1)) begin
                        rd_pix <= '0;
                        rd_ch  <= rd_ch + 2'd1;
                    end else begin
                        rd_pix <= rd_pix + PW'(1);
                    end
                end
            end else if (fin) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fmap_flatten.sv
// tb/tb_fmap_flatten.sv - randomized bench for fmap_flatten against a frame-level queue model
module tb_fmap_flatten;
    localparam int DB = 12;
    localparam int N  = 36;
    localparam int F  = 108;
`ifdef FMAP_PINGPONG_EN
    localparam int NBANKS = 2;
`else
    localparam int NBANKS = 1;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [DB-1:0] in0 = '0;
    logic signed [DB-1:0] in1 = '0;
    logic signed [DB-1:0] in2 = '0;
    logic                 valid_in = 1'b0;
    logic                 out_ready = 1'b0;
    logic signed [DB-1:0] out_data;
    logic [7:0]           out_index;
    logic                 out_valid;
    logic                 out_last;
    logic                 frame_done;
    logic                 overflow;

    fmap_flatten dut (
        .clk       (clk),
        .rst       (rst),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .valid_in  (valid_in),
        .out_data  (out_data),
        .out_index (out_index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .frame_done(frame_done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [DB-1:0] data;
        int                   idx;
        logic                 last;
    } smp_t;

    smp_t                 exp_q[$];
    logic signed [DB-1:0] f0[N];
    logic signed [DB-1:0] f1[N];
    logic signed [DB-1:0] f2[N];
    int                   fill_cnt = 0;
    int                   total = 0;
    int                   bad = 0;
    int                   popped = 0;
    int                   ncnt = 0;
    int                   lat_n = 0;
    int                   rdy_mode = 0;
    bit                   lat_arm = 0;
    bit                   exp_ovf = 0;
    bit                   fd_next = 0;
    bit                   prev_stall = 0;
    bit                   rst_seen = 0;
    logic signed [DB-1:0] prev_data;
    logic [7:0]           prev_idx;
    logic                 prev_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 2) == 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Sampled at negedge: inputs and outputs here are exactly what the next rising edge acts on.
    always @(negedge clk) begin
        int   qs;
        int   pend;
        smp_t e;
        ncnt++;
        if (rst) begin
            if (rst_seen) begin
                check("rst_data", out_data, 0);
                check("rst_index", out_index, 0);
                check("rst_valid", out_valid, 0);
                check("rst_last", out_last, 0);
                check("rst_frame_done", frame_done, 0);
                check("rst_overflow", overflow, 0);
            end
            rst_seen = 1;
            exp_q.delete();
            fill_cnt   = 0;
            exp_ovf    = 0;
            fd_next    = 0;
            prev_stall = 0;
            lat_arm    = 0;
        end else begin
            rst_seen = 0;
            qs = exp_q.size();
            check("frame_done", frame_done, fd_next);
            check("overflow", overflow, exp_ovf);
            if (prev_stall) begin
                check("stall_data", out_data, prev_data);
                check("stall_index", out_index, prev_idx);
                check("stall_last", out_last, prev_last);
            end
            if (qs == 0)
                check("idle_valid", out_valid, 0);
            if (lat_arm && out_valid) begin
                check("first_valid_latency", ncnt - lat_n, 2);
                lat_arm = 0;
            end
            fd_next = 0;
            if (out_valid && out_ready && qs > 0) begin
                e = exp_q.pop_front();
                popped++;
                check("data", out_data, e.data);
                check("index", out_index, e.idx);
                check("last", out_last, e.last);
                fd_next = e.last;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = out_index;
            prev_last  = out_last;
            if (valid_in) begin
                pend = (qs + F - 1) / F;
                if (pend >= NBANKS) begin
                    exp_ovf = 1;
                end else begin
                    f0[fill_cnt] = in0;
                    f1[fill_cnt] = in1;
                    f2[fill_cnt] = in2;
                    fill_cnt++;
                    if (fill_cnt == N) begin
                        fill_cnt = 0;
                        if (qs == 0) begin
                            lat_arm = 1;
                            lat_n   = ncnt;
                        end
                        for (int k = 0; k < F; k++) begin
                            e.idx  = k;
                            e.last = (k == F - 1);
                            if (k / N == 0)      e.data = f0[k % N];
                            else if (k / N == 1) e.data = f1[k % N];
                            else                 e.data = f2[k % N];
                            exp_q.push_back(e);
                        end
                    end
                end
            end
        end
    end

    task automatic send_frame(input int kind, input int gap, input int cnt);
        for (int p = 0; p < cnt; p++) begin
            case (kind)
                0: begin
                    in0 = DB'(p);
                    in1 = DB'(100 + p);
                    in2 = DB'(-(p + 1));
                end
                1: begin
                    in0 = DB'($urandom);
                    in1 = DB'($urandom);
                    in2 = DB'($urandom);
                end
                default: begin
                    in0 = DB'(500 + p);
                    in1 = DB'($urandom);
                    in2 = DB'($urandom);
                end
            endcase
            valid_in = 1'b1;
            @(posedge clk); #1;
            valid_in = 1'b0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_drain();
        int i = 0;
        while (exp_q.size() != 0 && i < 3000) begin
            @(posedge clk); #1;
            i++;
        end
        check("drain_done", exp_q.size(), 0);
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        popped = 0;
        send_frame(0, 0, N);
        wait_drain();
        check("fill_stream_count", popped, F);

        rdy_mode = 1;
        popped = 0;
        send_frame(0, 0, N);
        wait_drain();
        check("backpressure_count", popped, F);
        rdy_mode = 0;

        send_frame(1, 0, N);
        for (int i = 0; i < 400 && !(out_valid && out_index == 8'd50); i++) begin
            @(posedge clk); #1;
        end
        send_frame(1, 0, 1);
        wait_drain();
        check("overflow_sticky", overflow, (NBANKS == 1) ? 1 : 0);
        send_frame(1, 0, N);
        wait_drain();

        send_frame(1, 0, 20);
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        popped = 0;
        send_frame(2, 0, N);
        wait_drain();
        check("post_reset_count", popped, F);

        popped = 0;
        send_frame(0, 3, N);
        wait_drain();
        check("gapped_count", popped, F);

        rdy_mode = 1;
        send_frame(1, $urandom_range(0, 2), N);
        wait_drain();
        rdy_mode = 0;

`ifdef FMAP_PINGPONG_EN
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        popped = 0;
        send_frame(1, 0, N);
        send_frame(1, 0, N);
        wait_drain();
        check("pp_count", popped, 2 * F);
        check("pp_no_overflow", overflow, 0);

        rdy_mode = 2;
        repeat (2) begin
            @(posedge clk); #1;
        end
        send_frame(1, 0, N);
        send_frame(1, 0, N);
        check("pp_pre_overflow", overflow, 0);
        send_frame(1, 0, 1);
        check("pp_overflow", overflow, 1);
        rdy_mode = 0;
        wait_drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fmap_flatten.md
# fmap_flatten

Captures the pooled 6x6x3 feature map streamed out of the second convolution stage and replays it as a single flattened, channel-major stream to the dense (fully-connected) layer. It is the receiving end of the conv-stage output interface: a 3-channel, 12-bit signed, valid-only stream. It turns that stream into a ready/valid handshake that the dense layer can throttle. It sits between the conv2/pool stage and the classifier.

## Interface
- DATA_BITS, 12, sample width (signed)
- MAP_W, 6, pooled map width
- MAP_H, 6, pooled map height
- `clk` in 1: sole clock, rising edge
- `rst` in 1: reset, synchronous, active-high
- `in0`, `in1`, `in2` in DATA_BITS each: signed channel 0/1/2 samples, raster order
- `valid_in` in 1: one triple per asserted cycle; there is no back-pressure
- `out_data` out DATA_BITS: signed flattened sample
- `out_index` out 8: flat index of `out_data`, 0..3*MAP_W*MAP_H-1
- `out_valid` out 1: `out_data`/`out_index`/`out_last` are valid
- `out_ready` in 1: dense layer accepts on `out_valid && out_ready`
- `out_last` out 1: marks index 107 (the last sample)
- `frame_done` out 1: one-cycle pulse after the last handshake
- `overflow` out 1: sticky; a `valid_in` triple was dropped

## Operation
- N = MAP_W*MAP_H = 36 pixels. F = 3*N = 108 flat samples.
- Storage: three N-entry arrays, one per channel. Storage is not cleared by reset.
- State FILL:
  - Each `valid_in` writes `in0`/`in1`/`in2` at address `wr_cnt`, then `wr_cnt` increments.
  - On the write at `wr_cnt == N-1`, `wr_cnt` resets to 0 and the state moves to DRAIN.
- State DRAIN, read pointer `rd_cnt` 0..F-1:
  - Output order is channel-major: `out_index = rd_cnt`.
  - `out_data` = channel `rd_cnt / N`, pixel `rd_cnt % N`. This matches a C×H×W flatten.
  - Each handshake advances `rd_cnt`.
  - On the handshake with `rd_cnt == F-1`:
    - `rd_cnt` resets to 0.
    - `frame_done` pulses.
    - The state returns to FILL.
- A `valid_in` that arrives in DRAIN is dropped and sets `overflow`. This includes the cycle of the final handshake.
- Only `rst` clears `overflow`.
- Widths: data passes through bit-exact with no arithmetic. `out_index` is zero-extended.

## Timing
- Reset values: `out_data`=0, `out_index`=0, `out_valid`=0, `out_last`=0, `frame_done`=0, `overflow`=0. State is FILL and both counters are 0.
- Outputs are registered. Storage read has 1-cycle latency, and the next word is prefetched.
- The 36th `valid_in` at cycle T gives:
  - state DRAIN at T+1;
  - `out_valid`=1 with index 0 at T+2.
- With `out_ready` held high, one sample transfers per cycle. Index 107 handshakes at T+109.
- Stall: while `out_valid && !out_ready`, `out_data`, `out_index` and `out_last` hold stable.
- `out_ready` may toggle arbitrarily. No sample may be skipped or duplicated.
- Last handshake at cycle L gives:
  - `out_valid`=0, `out_last`=0 and `frame_done`=1 at L+1;
  - state FILL at L+1;
  - the first `valid_in` is accepted at L+1.
- `frame_done` is high for exactly one cycle.
- `rst` mid-fill or mid-drain: counters clear and the partial frame is discarded. The next `valid_in` after reset is pixel 0 of a new frame.

## Configuration
- `FMAP_PINGPONG_EN` defined:
  - Storage is duplicated into banks A and B, each with a full flag.
  - Fill targets the non-full bank, and drain reads the full bank. Banks alternate, starting with A.
  - `valid_in` is accepted in any state while the fill bank is not full.
  - Drain of the next bank starts one cycle after the previous `frame_done` if that bank is full. Otherwise it starts as soon as that bank completes.
  - `overflow` sets only when `valid_in` arrives with both banks full.
- `FMAP_PINGPONG_EN` undefined: single bank, with the FILL/DRAIN behaviour above.

## Test plan
- Fill and stream:
  - Stimulus: 36 triples with ch0=p, ch1=100+p, ch2=-(p+1), `out_ready`=1.
  - Required: indices 0..107, in order, with data 0..35, then 100..135, then -1..-36.
  - Required: `out_valid` first high 2 cycles after the 36th write.
  - Required: `out_last` only at 107, and `frame_done` one cycle after it.
- Back-pressure:
  - Stimulus: same frame; `out_ready` 1-of-3 cycles, pseudo-random.
  - Required: an identical sequence, and stable outputs during every stall.
- Overflow:
  - Stimulus: `valid_in` pulse during DRAIN at index 50.
  - Required: `overflow`=1 and stays 1; the streamed data is unchanged.
  - Required: the next full frame streams correctly.
- Reset mid-operation:
  - Stimulus: assert `rst` after 20 writes, then send a full new frame with values 500+p.
  - Required: all outputs 0 during reset; the output starts at 500, not at a stale value.
- Gapped input:
  - Stimulus: `valid_in` duty 1-of-4 for 36 triples.
  - Required: the same output as the first scenario.
- Ping-pong (macro on):
  - Stimulus: two back-to-back frames, 72 consecutive `valid_in` with `out_ready`=1.
  - Required: no `overflow`, and 216 samples with frame 2 directly following frame 1.
  - Stimulus: a third frame with `out_ready`=0.
  - Required: `overflow` asserts on its first triple.
